md5core_input_buf: RTL and testbench

- Per-core input block buffer. Sits directly downstream of the per-core write fan-out, one instance per md5 core.
- Stores 16×32-bit message blocks for the core's 4 threads (2 contexts × 2 sequences) in 4 independent slots.
- Tracks which slots hold a complete block. Streams a full block into the md5 core in round-robin slot order.

---
 rtl/md5core_input_buf_pkg.sv | 47 ++++
 rtl/md5core_input_buf_ram.sv | 40 ++++
 rtl/md5core_input_buf.sv | 174 +++++++++++++++++
 tb/tb_md5core_input_buf.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/md5core_input_buf_pkg.sv
// Shared types for the per-core md5 input block buffer: slot/read-FSM encodings
// and the round-robin slot picker.
package md5core_input_buf_pkg;

  localparam int N_SLOTS    = 4;
  localparam int DATA_WIDTH = 32;
  localparam int BLK_OP_MSB = 1;

  typedef logic [BLK_OP_MSB:0] blk_op_t;
  typedef logic [1:0]          slot_idx_t;
  typedef logic [3:0]          word_idx_t;

  typedef enum logic [1:0] {
    SLOT_EMPTY = 2'd0,
    SLOT_FULL  = 2'd1,
    SLOT_BUSY  = 2'd2
  } slot_state_e;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_READ  = 2'd1,
    RD_DRAIN = 2'd2
  } rd_state_e;

  typedef struct packed {
    logic      found;
    slot_idx_t idx;
  } rr_pick_t;

  // First set bit of full at or after ptr, wrapping; scanning downwards lets
  // the nearest candidate overwrite any farther one.
  function automatic rr_pick_t rr_pick(input logic [N_SLOTS-1:0] full,
                                       input slot_idx_t          ptr);
    rr_pick_t  res;
    slot_idx_t idx;
    res = '0;
    for (int k = N_SLOTS - 1; k >= 0; k--) begin
      idx = ptr + slot_idx_t'(k);
      if (full[idx]) begin
        res.found = 1'b1;
        res.idx   = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/md5core_input_buf_ram.sv
// Single-write, registered-read RAM used as block storage for a core buffer.
// The read register holds its value while rd_en is low.
module md5core_input_buf_ram #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  // NOTE: the array has no reset so it can map onto RAM primitives; only the
  // read register is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // NOTE: combinational blocks use blocking '=', clocked blocks use '<=' so
  // every flop samples pre-edge values regardless of statement order.
  always_comb begin
    rd_data_d = rd_en ? mem_q[rd_addr] : rd_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/md5core_input_buf.sv
// Per-core input buffer: four thread slots of 16 words each, filled from the
// write fan-out and streamed to the md5 core one block at a time, round-robin.
module md5core_input_buf
  import md5core_input_buf_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  wr_en,
  input  logic [3:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  input_ctx,
  input  logic                  input_seq,
  input  blk_op_t               blk_op,
  input  logic                  set_input_ready,
  output logic [N_SLOTS-1:0]    slot_empty,
  input  logic                  core_ready,
  output logic [DATA_WIDTH-1:0] core_dout,
  output logic                  core_dout_valid,
  output logic [3:0]            core_dout_addr,
  output logic                  core_blk_start,
  output logic [1:0]            core_thread,
  output blk_op_t               core_blk_op,
  output logic                  slot_done,
  output logic                  err
);

  slot_state_e          state_q [N_SLOTS];
  slot_state_e          state_d [N_SLOTS];
  blk_op_t              tag_q   [N_SLOTS];
  blk_op_t              tag_d   [N_SLOTS];
  logic [N_SLOTS-1:0]   slot_empty_q, slot_empty_d;
  rd_state_e            fsm_q, fsm_d;
  slot_idx_t            rr_ptr_q, rr_ptr_d;
  slot_idx_t            thread_q, thread_d;
  blk_op_t              blk_op_q, blk_op_d;
  word_idx_t            rd_cnt_q, rd_cnt_d;
  word_idx_t            dout_addr_q, dout_addr_d;
  logic                 valid_q, valid_d;
  logic                 blk_start_q, blk_start_d;
  logic                 slot_done_q, slot_done_d;
  logic                 err_q, err_d;

  logic [N_SLOTS-1:0]   full_vec;
  rr_pick_t             pick;
  slot_idx_t            wr_slot;
  logic                 rd_en;

  assign wr_slot = {input_ctx, input_seq};

  md5core_input_buf_ram #(
    .ADDR_W (6),
    .DATA_W (DATA_WIDTH)
  ) u_ram (
    .clk     (CLK),
    .rst     (RST),
    .wr_en   (wr_en),
    .wr_addr ({wr_slot, wr_addr}),
    .wr_data (din),
    .rd_en   (rd_en),
    .rd_addr ({thread_q, rd_cnt_q}),
    .rd_data (core_dout)
  );

  always_comb begin
    for (int i = 0; i < N_SLOTS; i++) full_vec[i] = (state_q[i] == SLOT_FULL);
    pick = rr_pick(full_vec, rr_ptr_q);
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned and infers a latch.
    state_d     = state_q;
    tag_d       = tag_q;
    fsm_d       = fsm_q;
    rr_ptr_d    = rr_ptr_q;
    thread_d    = thread_q;
    blk_op_d    = blk_op_q;
    rd_cnt_d    = rd_cnt_q;
    dout_addr_d = dout_addr_q;
    valid_d     = 1'b0;
    blk_start_d = 1'b0;
    slot_done_d = 1'b0;
    err_d       = err_q;
    rd_en       = 1'b0;

    // Upstream side works only from state_q, so a slot completed this cycle
    // cannot be picked by the read side until the next one.
    if (set_input_ready) begin
      if (state_q[wr_slot] == SLOT_EMPTY) begin
        state_d[wr_slot] = SLOT_FULL;
        tag_d[wr_slot]   = blk_op;
      end else begin
        err_d = 1'b1;
      end
    end
    if (wr_en && state_q[wr_slot] == SLOT_BUSY) err_d = 1'b1;

    unique case (fsm_q)
      RD_IDLE: begin
        if (core_ready && pick.found) begin
          thread_d           = pick.idx;
          blk_op_d           = tag_q[pick.idx];
          state_d[pick.idx]  = SLOT_BUSY;
          rd_cnt_d           = '0;
          fsm_d              = RD_READ;
        end
      end
      RD_READ: begin
        rd_en       = 1'b1;
        valid_d     = 1'b1;
        dout_addr_d = rd_cnt_q;
        blk_start_d = (rd_cnt_q == '0);
        rd_cnt_d    = rd_cnt_q + word_idx_t'(1);
        if (rd_cnt_q == word_idx_t'(15)) begin
          rr_ptr_d = thread_q + slot_idx_t'(1);
          fsm_d    = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        // Word 15 is on the output this cycle; the slot frees at the edge.
        state_d[thread_q] = SLOT_EMPTY;
        slot_done_d       = 1'b1;
        fsm_d             = RD_IDLE;
      end
      default: fsm_d = RD_IDLE;
    endcase

    for (int i = 0; i < N_SLOTS; i++) slot_empty_d[i] = (state_d[i] == SLOT_EMPTY);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        state_q[i] <= SLOT_EMPTY;
        tag_q[i]   <= '0;
      end
      slot_empty_q <= '1;
      fsm_q        <= RD_IDLE;
      rr_ptr_q     <= '0;
      thread_q     <= '0;
      blk_op_q     <= '0;
      rd_cnt_q     <= '0;
      dout_addr_q  <= '0;
      valid_q      <= 1'b0;
      blk_start_q  <= 1'b0;
      slot_done_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      slot_empty_q <= slot_empty_d;
      fsm_q        <= fsm_d;
      rr_ptr_q     <= rr_ptr_d;
      thread_q     <= thread_d;
      blk_op_q     <= blk_op_d;
      rd_cnt_q     <= rd_cnt_d;
      dout_addr_q  <= dout_addr_d;
      valid_q      <= valid_d;
      blk_start_q  <= blk_start_d;
      slot_done_q  <= slot_done_d;
      err_q        <= err_d;
    end
  end

  assign slot_empty      = slot_empty_q;
  assign core_dout_valid = valid_q;
  assign core_dout_addr  = dout_addr_q;
  assign core_blk_start  = blk_start_q;
  assign core_thread     = thread_q;
  assign core_blk_op     = blk_op_q;
  assign slot_done       = slot_done_q;
  assign err             = err_q;

endmodule

// File: tb/tb_md5core_input_buf.sv
// Directed bench for md5core_input_buf: fill/stream, round-robin order,
// protocol errors, mid-block reset and concurrent fill while streaming.
module tb_md5core_input_buf;
  import md5core_input_buf_pkg::*;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] din;
  logic        input_ctx;
  logic        input_seq;
  blk_op_t     blk_op;
  logic        set_input_ready;
  logic [3:0]  slot_empty;
  logic        core_ready;
  logic [31:0] core_dout;
  logic        core_dout_valid;
  logic [3:0]  core_dout_addr;
  logic        core_blk_start;
  logic [1:0]  core_thread;
  blk_op_t     core_blk_op;
  logic        slot_done;
  logic        err;

  int checks = 0;
  int errors = 0;

  md5core_input_buf dut (
    .CLK             (clk),
    .RST             (rst),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .din             (din),
    .input_ctx       (input_ctx),
    .input_seq       (input_seq),
    .blk_op          (blk_op),
    .set_input_ready (set_input_ready),
    .slot_empty      (slot_empty),
    .core_ready      (core_ready),
    .core_dout       (core_dout),
    .core_dout_valid (core_dout_valid),
    .core_dout_addr  (core_dout_addr),
    .core_blk_start  (core_blk_start),
    .core_thread     (core_thread),
    .core_blk_op     (core_blk_op),
    .slot_done       (slot_done),
    .err             (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Writes words base+0..base+15 into slot {c,s}; set_input_ready rides with word 15.
  task automatic fill_block(input logic c, input logic s, input logic [31:0] base, input blk_op_t op);
    for (int i = 0; i < 16; i++) begin
      wr_en           = 1'b1;
      wr_addr         = 4'(i);
      din             = base + 32'(i);
      input_ctx       = c;
      input_seq       = s;
      blk_op          = op;
      set_input_ready = (i == 15);
      @(negedge clk);
    end
    wr_en           = 1'b0;
    set_input_ready = 1'b0;
  endtask

  // Waits (bounded) for word 0, then checks all 16 words; ends on word 15's cycle.
  task automatic expect_block(input string tag, input logic [1:0] thr, input blk_op_t op,
                              input logic [31:0] base);
    int n;
    n = 0;
    while (core_blk_start !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("%s_start_seen", tag), 32'(core_blk_start), 32'd1);
    if (core_blk_start !== 1'b1) return;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("%s_valid%0d", tag, i), 32'(core_dout_valid), 32'd1);
      check($sformatf("%s_addr%0d", tag, i), 32'(core_dout_addr), 32'(i));
      check($sformatf("%s_data%0d", tag, i), core_dout, base + 32'(i));
      check($sformatf("%s_thread%0d", tag, i), 32'(core_thread), 32'(thr));
      check($sformatf("%s_op%0d", tag, i), 32'(core_blk_op), 32'(op));
      check($sformatf("%s_bstart%0d", tag, i), 32'(core_blk_start), 32'(i == 0));
    end
  endtask

  initial begin
    int starts;
    int dones;
    int seen;
    int start_cyc [4];
    int thr_seen  [4];

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; din = '0; input_ctx = 1'b0; input_seq = 1'b0;
    blk_op = '0; set_input_ready = 1'b0; core_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin start_cyc[k] = 0; thr_seen[k] = 0; end

    // Reset state
    @(negedge clk);
    check("rst_slot_empty", 32'(slot_empty), 32'hF);
    check("rst_valid", 32'(core_dout_valid), 32'd0);
    check("rst_dout", core_dout, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_done", 32'(slot_done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Test 1: one block through slot 2
    core_ready = 1'b1;
    fill_block(1'b1, 1'b0, 32'h100, 2'd1);
    check("t1_slot_empty_full", 32'(slot_empty), 32'hB);
    expect_block("t1", 2'd2, 2'd1, 32'h100);
    @(negedge clk);
    check("t1_slot_done", 32'(slot_done), 32'd1);
    check("t1_slot_empty_free", 32'(slot_empty), 32'hF);
    check("t1_valid_off", 32'(core_dout_valid), 32'd0);
    @(negedge clk);
    check("t1_slot_done_pulse", 32'(slot_done), 32'd0);

    // Test 2: four full slots stream in order 0..3, 18 cycles apart
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    core_ready = 1'b0;
    for (int k = 0; k < 4; k++)
      fill_block(k[1], k[0], 32'h2000 + 32'(k) * 32'h100, blk_op_t'(k));
    check("t2_all_full", 32'(slot_empty), 32'h0);
    core_ready = 1'b1;
    starts = 0;
    dones  = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (core_blk_start === 1'b1) begin
        if (starts < 4) begin
          start_cyc[starts] = c;
          thr_seen[starts]  = int'(core_thread);
          check($sformatf("t2_word0_blk%0d", starts), core_dout,
                32'h2000 + 32'(core_thread) * 32'h100);
        end
        starts++;
      end
      if (slot_done === 1'b1) dones++;
    end
    check("t2_starts", 32'(starts), 32'd4);
    check("t2_dones", 32'(dones), 32'd4);
    for (int k = 0; k < 4; k++) check($sformatf("t2_order%0d", k), 32'(thr_seen[k]), 32'(k));
    for (int k = 0; k < 3; k++)
      check($sformatf("t2_gap%0d", k), 32'(start_cyc[k+1] - start_cyc[k]), 32'd18);
    check("t2_slot_empty_end", 32'(slot_empty), 32'hF);

    // Test 3: rr_ptr=2 after slot 1, then slots 0 and 3 both full -> 3 first
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    core_ready = 1'b1;
    fill_block(1'b0, 1'b1, 32'h3100, 2'd2);
    expect_block("t3a", 2'd1, 2'd2, 32'h3100);
    core_ready = 1'b0;
    repeat (3) @(negedge clk);
    fill_block(1'b0, 1'b0, 32'h3000, 2'd0);
    fill_block(1'b1, 1'b1, 32'h3300, 2'd3);
    check("t3_slot_empty", 32'(slot_empty), 32'h6);
    core_ready = 1'b1;
    expect_block("t3b", 2'd3, 2'd3, 32'h3300);
    expect_block("t3c", 2'd0, 2'd0, 32'h3000);

    // Test 4: set_input_ready on a FULL slot sets err; slot streams once, tag kept
    core_ready = 1'b0;
    repeat (3) @(negedge clk);
    fill_block(1'b0, 1'b1, 32'h4100, 2'd1);
    check("t4_err_before", 32'(err), 32'd0);
    input_ctx = 1'b0; input_seq = 1'b1; blk_op = 2'd3; set_input_ready = 1'b1;
    @(negedge clk);
    set_input_ready = 1'b0;
    check("t4_err_set", 32'(err), 32'd1);
    check("t4_slot_empty", 32'(slot_empty), 32'hD);
    core_ready = 1'b1;
    expect_block("t4", 2'd1, 2'd1, 32'h4100);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (core_blk_start === 1'b1) seen++;
    end
    check("t4_no_restream", 32'(seen), 32'd0);
    check("t4_err_sticky", 32'(err), 32'd1);

    // Test 5: asynchronous reset at word 7
    fill_block(1'b0, 1'b0, 32'h5000, 2'd2);
    seen = 0;
    while (core_blk_start !== 1'b1 && seen < 60) begin
      @(negedge clk);
      seen++;
    end
    check("t5_start_seen", 32'(core_blk_start), 32'd1);
    repeat (7) @(negedge clk);
    check("t5_word7", core_dout, 32'h5007);
    rst = 1'b1;
    #1;
    check("t5_valid", 32'(core_dout_valid), 32'd0);
    check("t5_bstart", 32'(core_blk_start), 32'd0);
    check("t5_done", 32'(slot_done), 32'd0);
    check("t5_dout", core_dout, 32'd0);
    check("t5_addr", 32'(core_dout_addr), 32'd0);
    check("t5_thread", 32'(core_thread), 32'd0);
    check("t5_op", 32'(core_blk_op), 32'd0);
    check("t5_slot_empty", 32'(slot_empty), 32'hF);
    check("t5_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (core_dout_valid !== 1'b0 || slot_done !== 1'b0) seen++;
    end
    check("t5_quiet_after", 32'(seen), 32'd0);

    // Test 6: fill slot 1 while slot 0 streams with core_ready low
    core_ready = 1'b0;
    fill_block(1'b0, 1'b0, 32'h6000, 2'd1);
    core_ready = 1'b1;
    @(negedge clk);
    core_ready = 1'b0;
    fork
      expect_block("t6a", 2'd0, 2'd1, 32'h6000);
      fill_block(1'b0, 1'b1, 32'h6100, 2'd2);
    join
    check("t6_slot_empty", 32'(slot_empty), 32'hC);
    check("t6_err", 32'(err), 32'd0);
    repeat (4) @(negedge clk);
    check("t6_hold_idle", 32'(core_dout_valid), 32'd0);
    core_ready = 1'b1;
    expect_block("t6b", 2'd1, 2'd2, 32'h6100);
    @(negedge clk);
    check("t6_done", 32'(slot_done), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
